// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared definitions for the digit-serial BCD adder.
//               Holds the digit width, the largest legal BCD digit, the
//               control state encoding and the nines-complement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 9 - d. Wraps for illegal digits 10..15, which map onto 15..10, so an
    // illegal digit stays illegal after complementing.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : Combinational single-digit BCD adder with decimal carry.
//               Ports: a, b (BCD digits), ci (carry in) -> s (BCD digit),
//               co (decimal carry out), inval (either digit above 9).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       inval
);
    import bcd_pkg::*;

    logic [4:0] w_t;
    logic [4:0] w_adj;

    assign w_t   = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    assign w_adj = w_t + 5'd6;

    always_comb begin
        s  = w_t[3:0];
        co = 1'b0;
        // Above 9 the binary sum skips the six unused codes to wrap decimally.
        if (w_t > {1'b0, BCD_MAX}) begin
            s  = w_adj[3:0];
            co = 1'b1;
        end
    end

    assign inval = (a > BCD_MAX) || (b > BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder
// Description : Digit-serial packed-BCD adder, one decimal digit per clock,
//               least significant digit first, start/busy/done handshake.
//               Ports: clk, rst (async, active high), start, sub, cin,
//               a, b (4*DIGITS packed BCD) -> busy, done, sum, cout, err.
//               Optional macro SUBTRACT_EN: sub=1 computes A-B in ten's
//               complement (cout=1 means no borrow). Without it, sub is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    import bcd_pkg::*;

    localparam int                 IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(DIGITS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic [4*DIGITS-1:0]    r_a;
    logic [4*DIGITS-1:0]    r_b;
    logic [4*DIGITS-1:0]    r_sum;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_err;
    logic                   w_carry_init;
    logic [3:0]             w_b_dig;
    logic [3:0]             w_dig;
    logic                   w_co;
    logic                   w_inval;

`ifdef SUBTRACT_EN
    logic r_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end
    end

    // Subtraction adds the nines complement of B plus one.
    assign w_carry_init = sub ? 1'b1 : cin;
    assign w_b_dig      = r_sub ? nines_comp(r_b[3:0]) : r_b[3:0];
`else
    logic w_unused_sub;

    assign w_unused_sub = sub;
    assign w_carry_init = cin;
    assign w_b_dig      = r_b[3:0];
`endif

    // Single digit adder shared by all digits; operands shift down so the
    // current digit is always in the low nibble. The validity flag of the
    // complemented digit matches the raw digit (see nines_comp).
    bcd_digit_add u_digit (
        .a     (r_a[3:0]),
        .b     (w_b_dig),
        .ci    (r_carry),
        .s     (w_dig),
        .co    (w_co),
        .inval (w_inval)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == C_LAST) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= w_carry_init;
            r_err   <= 1'b0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*DIGIT_W +: DIGIT_W] <= w_dig;
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_idx   <= r_idx + 1'b1;
            r_carry <= w_co;
            r_err   <= r_err | w_inval;
            if (r_idx == C_LAST) r_cout <= w_co;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_adder
// Description : Self-checking bench for bcd_serial_adder (DIGITS=4) using a
//               decimal reference model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int MODV   = 10000;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        bit          chk_sum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int          x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                   input logic tcin, input logic tsub);
        exp_t e;
        int   r;
        bit   inv = 1'b0;
        bit   do_sub = 1'b0;
`ifdef SUBTRACT_EN
        do_sub = tsub;
`endif
        for (int i = 0; i < DIGITS; i++)
            if (ta[i*4 +: 4] > 4'd9 || tb_[i*4 +: 4] > 4'd9) inv = 1'b1;
        if (do_sub) r = bcd2int(ta) + (MODV - 1 - bcd2int(tb_)) + 1;
        else        r = bcd2int(ta) + bcd2int(tb_) + int'(tcin);
        e.sum     = int2bcd(r % MODV);
        e.cout    = (r >= MODV);
        e.err     = inv;
        e.chk_sum = !inv;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Called at a negedge: drives a one-cycle start and records the expectation.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsub);
        exp_q.push_back(model(ta, tb_, tcin, tsub));
        start = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, optionally poking start mid-run, then
    // compares against the scoreboard. Returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input bit poke);
        int   n = 0;
        int   guard = 0;
        exp_t e;
        while (!done && guard < 40) begin
            if (busy) n++;
            if (poke && n == 2) begin
                start = 1'b1; a = 16'h9999; b = 16'h9999; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_cycles"}, n, DIGITS);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            if (e.chk_sum) chk({tag, ".sum"}, sum, e.sum);
            if (e.chk_sum) chk({tag, ".cout"}, {31'd0, cout}, {31'd0, e.cout});
            chk({tag, ".err"}, {31'd0, err}, {31'd0, e.err});
        end
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.sum",  sum, 32'd0);
        chk("reset.cout", {31'd0, cout}, 32'd0);
        chk("reset.err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_done("add_1234_5678", 1'b0);
        chk("add_1234_5678.const", sum, 32'h6912);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("sum_held_idle", sum, 32'h6912);

        issue(16'h9999, 16'h0001, 1'b0, 1'b0);
        wait_done("add_9999_0001", 1'b0);
        chk("add_9999_0001.cout_const", {31'd0, cout}, 32'd1);
        @(negedge clk);

        issue(16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_done("add_cin", 1'b0);
        chk("add_cin.const", sum, 32'h0001);
        @(negedge clk);

        issue(16'h12A4, 16'h0000, 1'b0, 1'b0);
        wait_done("invalid_digit", 1'b0);
        @(negedge clk);

        issue(16'h0042, 16'h0013, 1'b0, 1'b0);
        wait_done("valid_after_err", 1'b0);
        @(negedge clk);

        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_done("start_while_busy", 1'b1);
        chk("start_while_busy.const", sum, 32'h3333);

        // Back-to-back: start during the DONE cycle.
        issue(16'h0808, 16'h0303, 1'b0, 1'b0);
        chk("b2b.done_dropped", {31'd0, done}, 32'd0);
        chk("b2b.busy", {31'd0, busy}, 32'd1);
        wait_done("b2b", 1'b0);
        @(negedge clk);

        // Reset during the second RUN cycle.
        issue(16'h4321, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.sum",  sum, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.err",  {31'd0, err}, 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort.no_done", {31'd0, seen_done}, 32'd0);

        issue(16'h0005, 16'h0005, 1'b0, 1'b0);
        wait_done("add_5_5", 1'b0);
        chk("add_5_5.const", sum, 32'h0010);
        @(negedge clk);

        issue(16'h5000, 16'h1234, 1'b0, 1'b1);
        wait_done("sub_5000_1234", 1'b0);
`ifdef SUBTRACT_EN
        chk("sub_5000_1234.const", sum, 32'h3766);
`else
        chk("sub_ignored.const", sum, 32'h6234);
`endif
        @(negedge clk);

        issue(16'h1234, 16'h5000, 1'b0, 1'b1);
        wait_done("sub_1234_5000", 1'b0);
        chk("sub_1234_5000.const", sum, 32'h6234);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
